distance_text_buffer: RTL

DISTANCE_TEXT_BUFFER -- requirements
Module: distance_text_buffer

---
 rtl/distance_meter_pkg.sv | 38 +++
 rtl/bin2bcd_seq.sv | 53 +++++
 rtl/distance_text_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/distance_meter_pkg.sv
// ============================================================================
//  Module  : distance_meter_pkg
//  Purpose : Shared ASCII, text-layout and FSM constants for the distance display
//  Revision: 1.0
// ============================================================================
`default_nettype none

package distance_meter_pkg;

    localparam logic [6:0]  C_ASCII_SPACE = 7'h20;
    localparam logic [6:0]  C_ASCII_DASH  = 7'h2D;
    localparam logic [6:0]  C_ASCII_ZERO  = 7'h30;

    localparam int          C_DIGIT_COL   = 6;
    localparam int          C_DIGIT_WIDTH = 5;
    localparam logic [15:0] C_NO_ECHO     = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    // Adds 3 to every BCD nibble of 5 or more, ahead of the next left shift
    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        logic [19:0] adj;
        adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
//  Module  : bin2bcd_seq
//  Purpose : Sequential shift-add-3 converter, 16-bit binary to 5 BCD digits
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import distance_meter_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_count;
    logic        r_active;
    logic [19:0] w_adj;

    assign w_adj = bcd_adjust(r_bcd);

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (start && !r_active) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_count  <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_count        <= r_count + 4'd1;
            if (r_count == 4'hF) begin
                r_active <= 1'b0;
            end
        end
    end

    // High during the final shift so the caller can write on the very next edge
    assign done = r_active && (r_count == 4'hF);
    assign bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/distance_text_buffer.sv
// ============================================================================
//  Module  : distance_text_buffer
//  Purpose : 4x16 text frame "DIST: ddddd cm" served to the char-drawing stage
//  Revision: 1.0
// ============================================================================
`default_nettype none

module distance_text_buffer
    import distance_meter_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [15:0] distance,
    input  logic        distance_valid,
    input  logic [5:0]  char_xy,
    output logic [6:0]  char_code,
    output logic        busy
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_start;
    logic        w_write;
    logic        w_done;
    logic [19:0] w_bcd;
    logic        r_busy;
    logic        r_no_echo;
    logic [6:0]  r_cell [C_DIGIT_WIDTH];
    logic [6:0]  w_fmt  [C_DIGIT_WIDTH];
    logic        w_leading;
    logic [3:0]  w_digit;
    logic [3:0]  w_rel;
    logic [6:0]  w_code;

    bin2bcd_seq u_bin2bcd (
        .pclk  (pclk),
        .rst   (rst),
        .start (w_start),
        .bin   (distance),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (distance_valid && !r_busy) begin
                    w_start      = 1'b1;
                    w_next_state = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (w_done) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_write      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Leading zeros blank to space; the units digit is always shown
    always_comb begin
        w_leading = 1'b1;
        w_digit   = '0;
        for (int i = 0; i < C_DIGIT_WIDTH; i++) begin
            w_digit = w_bcd[4*(C_DIGIT_WIDTH-1-i) +: 4];
            if (r_no_echo) begin
                w_fmt[i] = C_ASCII_DASH;
            end else if (w_leading && (w_digit == 4'd0) && (i != C_DIGIT_WIDTH-1)) begin
                w_fmt[i] = C_ASCII_SPACE;
            end else begin
                w_leading = 1'b0;
                w_fmt[i]  = C_ASCII_ZERO + {3'b000, w_digit};
            end
        end
    end

    // Busy lags the state by one edge so it spans capture+1 through the write edge
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_no_echo <= 1'b0;
            for (int i = 0; i < C_DIGIT_WIDTH; i++) begin
                r_cell[i] <= C_ASCII_DASH;
            end
        end else begin
            r_busy <= (r_state != ST_IDLE);
            if (w_start) begin
                r_no_echo <= (distance == C_NO_ECHO);
            end
            if (w_write) begin
                for (int i = 0; i < C_DIGIT_WIDTH; i++) begin
                    r_cell[i] <= w_fmt[i];
                end
            end
        end
    end

    assign w_rel = char_xy[3:0] - 4'(C_DIGIT_COL);

    always_comb begin
        w_code = C_ASCII_SPACE;
        if (char_xy[5:4] == 2'd0) begin
            case (char_xy[3:0])
                4'd0:  w_code = 7'h44;
                4'd1:  w_code = 7'h49;
                4'd2:  w_code = 7'h53;
                4'd3:  w_code = 7'h54;
                4'd4:  w_code = 7'h3A;
                4'd12: w_code = 7'h63;
                4'd13: w_code = 7'h6D;
                default: begin
                    if (w_rel < 4'(C_DIGIT_WIDTH)) begin
                        w_code = r_cell[w_rel[2:0]];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            char_code <= C_ASCII_SPACE;
        end else begin
            char_code <= w_code;
        end
    end

    assign busy = r_busy;

endmodule

`default_nettype wire
